// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: size codes, fault encodings, FSM states.
package lsu_pkg;

   localparam logic [2:0] MEM_B  = 3'b001;
   localparam logic [2:0] MEM_H  = 3'b010;
   localparam logic [2:0] MEM_W  = 3'b011;
   localparam logic [2:0] MEM_BU = 3'b101;
   localparam logic [2:0] MEM_HU = 3'b110;

   localparam logic [1:0] FAULT_OK      = 2'b00;
   localparam logic [1:0] FAULT_MISALGN = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b10;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b11;

   typedef logic [1:0] lsu_state_t;
   localparam lsu_state_t ST_IDLE   = 2'd0;
   localparam lsu_state_t ST_ACCESS = 2'd1;
   localparam lsu_state_t ST_DONE   = 2'd2;

endpackage

// File: rtl/lsu_if.sv
// Data-memory port: the LSU drives the request side, memory returns data and ack.
interface lsu_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;

   modport master (output req, we, addr, wstrb, wdata, input rdata, ack);
   modport slave  (input req, we, addr, wstrb, wdata, output rdata, ack);
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/replication, load lane select and extension,
// plus size-code legality and alignment checks.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  mem,
   input  logic [1:0]  alo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] load_ext,
   output logic        misaligned,
   output logic        illegal
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic        sext;

   assign lane_b = rdata[{alo, 3'b000} +: 8];
   assign lane_h = alo[1] ? rdata[31:16] : rdata[15:0];
   // bit 2 of the size code marks the unsigned variants
   assign sext   = ~mem[2];

   always_comb begin
      illegal = 1'b1;
      case (mem)
         MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: illegal = 1'b0;
         default:                             illegal = 1'b1;
      endcase
   end

   assign misaligned = ~illegal &
                       (((mem[1:0] == 2'b10) & alo[0]) |
                        ((mem[1:0] == 2'b11) & (alo != 2'b00)));

   always_comb begin
      wstrb    = 4'b0000;
      wdata    = store_data;
      load_ext = rdata;
      case (mem[1:0])
         2'b01: begin
            wstrb    = 4'b0001 << alo;
            wdata    = {4{store_data[7:0]}};
            load_ext = {{24{sext & lane_b[7]}}, lane_b};
         end
         2'b10: begin
            wstrb    = 4'b0011 << alo;
            wdata    = {2{store_data[15:0]}};
            load_ext = {{16{sext & lane_h[15]}}, lane_h};
         end
         2'b11: wstrb = 4'b1111;
         default: wstrb = 4'b0000;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one request/ack transaction per start, with
// alignment faults, illegal-code faults and an ack timeout.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  mem,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic [1:0]  fault,
   output logic [31:0] load_data,
   lsu_if.master       dmem
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   lsu_state_t  state;
   logic [CW-1:0] cnt;
   logic        is_store_q;
   logic [2:0]  mem_q;
   logic [1:0]  alo_q;
   logic        req_q, we_q;
   logic [31:0] daddr_q, wdata_q;
   logic [3:0]  wstrb_q;

   logic        idle;
   logic [2:0]  al_mem;
   logic [1:0]  al_alo;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata, al_load;
   logic        al_misal, al_illegal;

   // In IDLE the aligner checks the incoming request; afterwards it decodes
   // the registered request against the returning read data.
   assign idle   = (state == ST_IDLE);
   assign al_mem = idle ? mem : mem_q;
   assign al_alo = idle ? addr[1:0] : alo_q;

   lsu_align u_align (
      .mem        (al_mem),
      .alo        (al_alo),
      .store_data (store_data),
      .rdata      (dmem.rdata),
      .wstrb      (al_wstrb),
      .wdata      (al_wdata),
      .load_ext   (al_load),
      .misaligned (al_misal),
      .illegal    (al_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         is_store_q <= 1'b0;
         mem_q      <= 3'b000;
         alo_q      <= 2'b00;
         busy       <= 1'b0;
         done       <= 1'b0;
         fault      <= FAULT_OK;
         load_data  <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         daddr_q    <= '0;
         wstrb_q    <= '0;
         wdata_q    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: if (start) begin
               is_store_q <= is_store;
               mem_q      <= mem;
               alo_q      <= addr[1:0];
               cnt        <= '0;
               busy       <= 1'b1;
               if (al_illegal || al_misal) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  fault <= al_illegal ? FAULT_ILLEGAL : FAULT_MISALGN;
               end else begin
                  state   <= ST_ACCESS;
                  req_q   <= 1'b1;
                  we_q    <= is_store;
                  daddr_q <= {addr[31:2], 2'b00};
                  wstrb_q <= is_store ? al_wstrb : 4'b0000;
                  wdata_q <= al_wdata;
               end
            end
            ST_ACCESS: begin
               // ack takes priority over an expiring counter in the same cycle
               if (dmem.ack || cnt == CNT_LAST) begin
                  state   <= ST_DONE;
                  done    <= 1'b1;
                  fault   <= dmem.ack ? FAULT_OK : FAULT_TIMEOUT;
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  wstrb_q <= 4'b0000;
                  if (dmem.ack && !is_store_q) load_data <= al_load;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign dmem.req   = req_q;
   assign dmem.we    = we_q;
   assign dmem.addr  = daddr_q;
   assign dmem.wstrb = wstrb_q;
   assign dmem.wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk, rst_n;
   logic        start, is_store;
   logic [2:0]  mem;
   logic [31:0] addr, store_data;
   logic        busy, done;
   logic [1:0]  fault;
   logic [31:0] load_data;
   int          n_vec = 0;
   int          n_err = 0;

   lsu_if bus ();

   load_store_unit #(.TIMEOUT(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .is_store   (is_store),
      .mem        (mem),
      .addr       (addr),
      .store_data (store_data),
      .busy       (busy),
      .done       (done),
      .fault      (fault),
      .load_data  (load_data),
      .dmem       (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // start sampled on the next rising edge (cycle 0); returns at cycle 1 negedge
   task automatic issue(input logic st, input logic [2:0] m, input logic [31:0] a,
                        input logic [31:0] sd);
      @(negedge clk);
      start = 1'b1; is_store = st; mem = m; addr = a; store_data = sd;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " busy"},  busy, 0);
      chk({tag, " done"},  done, 0);
      chk({tag, " fault"}, fault, 0);
      chk({tag, " ldata"}, load_data, 0);
      chk({tag, " req"},   bus.req, 0);
      chk({tag, " we"},    bus.we, 0);
      chk({tag, " addr"},  bus.addr, 0);
      chk({tag, " wstrb"}, bus.wstrb, 0);
      chk({tag, " wdata"}, bus.wdata, 0);
   endtask

   initial begin
      int reqc, done_cyc;
      rst_n = 1'b0; start = 1'b0; is_store = 1'b0; mem = 3'b000;
      addr = '0; store_data = '0; bus.ack = 1'b0; bus.rdata = '0;
      repeat (2) @(negedge clk);
      chk_zero("rst");
      rst_n = 1'b1;

      // load byte signed, ack in cycle 1
      issue(0, MEM_B, 32'h103, 0);
      chk("lb req", bus.req, 1);
      chk("lb we", bus.we, 0);
      chk("lb wstrb", bus.wstrb, 0);
      chk("lb addr", bus.addr, 32'h100);
      chk("lb busy", busy, 1);
      chk("lb early done", done, 0);
      bus.rdata = 32'h80AA_BBCC; bus.ack = 1'b1;
      @(negedge clk); bus.ack = 1'b0;
      chk("lb done", done, 1);
      chk("lb fault", fault, FAULT_OK);
      chk("lb data", load_data, 32'hFFFF_FF80);
      chk("lb req drop", bus.req, 0);
      @(negedge clk);
      chk("lb idle busy", busy, 0);
      chk("lb done pulse", done, 0);

      // load half unsigned, three wait cycles; a start mid-access is ignored
      issue(0, MEM_HU, 32'h202, 0);
      bus.rdata = 32'h8001_1234;
      for (int c = 1; c <= 3; c++) begin
         chk("lhu wait req", bus.req, 1);
         chk("lhu wait done", done, 0);
         if (c == 2) begin start = 1'b1; is_store = 1'b1; mem = MEM_W; addr = '0; end
         @(negedge clk);
         start = 1'b0;
      end
      bus.ack = 1'b1;
      chk("lhu req c4", bus.req, 1);
      @(negedge clk); bus.ack = 1'b0;
      chk("lhu done c5", done, 1);
      chk("lhu fault", fault, FAULT_OK);
      chk("lhu data", load_data, 32'h0000_8001);
      @(negedge clk);
      chk("lhu busy after", busy, 0);
      chk("lhu no queued req", bus.req, 0);

      // store byte
      issue(1, MEM_B, 32'h41, 32'h1234_56A5);
      chk("sb req", bus.req, 1);
      chk("sb we", bus.we, 1);
      chk("sb wstrb", bus.wstrb, 4'b0010);
      chk("sb wdata", bus.wdata, 32'hA5A5_A5A5);
      chk("sb addr", bus.addr, 32'h40);
      bus.ack = 1'b1;
      @(negedge clk); bus.ack = 1'b0;
      chk("sb done", done, 1);
      chk("sb fault", fault, FAULT_OK);
      chk("sb ldata held", load_data, 32'h0000_8001);
      @(negedge clk);

      // store half upper lane
      issue(1, MEM_H, 32'h82, 32'hFFFF_BEEF);
      chk("sh wstrb", bus.wstrb, 4'b1100);
      chk("sh wdata", bus.wdata, 32'hBEEF_BEEF);
      bus.ack = 1'b1;
      @(negedge clk); bus.ack = 1'b0;
      chk("sh done", done, 1);

      // misaligned word, then back-to-back illegal code, then misaligned half
      issue(0, MEM_W, 32'h06, 0);
      chk("mw done", done, 1);
      chk("mw fault", fault, FAULT_MISALGN);
      chk("mw req", bus.req, 0);
      chk("mw ldata held", load_data, 32'h0000_8001);
      issue(0, 3'b111, 32'h0, 0);
      chk("ill done", done, 1);
      chk("ill fault", fault, FAULT_ILLEGAL);
      chk("ill req", bus.req, 0);
      issue(0, MEM_H, 32'h01, 0);
      chk("mh fault", fault, FAULT_MISALGN);
      chk("mh done", done, 1);

      // load half signed, lower lane
      issue(0, MEM_H, 32'h0, 0);
      bus.rdata = 32'h1234_F00D; bus.ack = 1'b1;
      @(negedge clk); bus.ack = 1'b0;
      chk("lh done", done, 1);
      chk("lh data", load_data, 32'hFFFF_F00D);
      @(negedge clk);

      // timeout: req for cycles 1..16, done with fault 10 in cycle 17
      issue(0, MEM_W, 32'h10, 0);
      reqc = 0; done_cyc = 0;
      for (int i = 1; i <= 24 && done_cyc == 0; i++) begin
         if (bus.req) reqc++;
         if (done) begin
            done_cyc = i;
            chk("to fault", fault, FAULT_TIMEOUT);
            chk("to req drop", bus.req, 0);
            chk("to ldata held", load_data, 32'hFFFF_F00D);
         end else begin
            @(negedge clk);
         end
      end
      chk("to req cycles", reqc, 16);
      chk("to done cycle", done_cyc, 17);
      @(negedge clk);

      // reset mid-access, then a stale ack
      issue(0, MEM_W, 32'h20, 0);
      @(negedge clk);
      chk("mid req", bus.req, 1);
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1; bus.rdata = 32'hDEAD_BEEF; bus.ack = 1'b1;
      @(negedge clk); bus.ack = 1'b0;
      chk("stale done", done, 0);
      chk("stale busy", busy, 0);
      chk("stale ldata", load_data, 0);
      @(negedge clk);
      chk("stale done2", done, 0);

      // fresh request after reset completes normally
      issue(0, MEM_BU, 32'h2, 0);
      bus.rdata = 32'h00C3_0000; bus.ack = 1'b1;
      @(negedge clk); bus.ack = 1'b0;
      chk("post done", done, 1);
      chk("post fault", fault, FAULT_OK);
      chk("post data", load_data, 32'h0000_00C3);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage of the 32-bit core. It consumes the memory-size code produced by the ALU control stage, the effective address from the ALU result, and the store operand. It then runs a request/acknowledge transaction on the data-memory port, with byte-lane alignment, write strobes, load sign/zero extension, misalignment detection and an acknowledge timeout. It sits between the execute stage and the write-back mux.

## Interface
- `TIMEOUT`, default 16: number of cycles to wait for `dmem_ack` before a bus fault.
- `clk` in 1: clock. All flops update on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request strobe. Sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load.
- `mem` in 3: size code.
  - 001 = byte signed
  - 010 = half signed
  - 011 = word
  - 101 = byte unsigned
  - 110 = half unsigned
  - any other value is illegal
- `addr` in 32: effective byte address.
- `store_data` in 32: store operand, taken from the low-order bits.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `fault` out 2: valid only with `done`.
  - 00 = ok
  - 01 = misaligned
  - 10 = bus timeout
  - 11 = illegal code
- `load_data` out 32: extended load result. Held until the next `done`.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: write enable.
- `dmem_addr` out 32: word-aligned address `{addr[31:2],2'b00}`.
- `dmem_wstrb` out 4: byte-lane write enables.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_rdata` in 32: read data.
- `dmem_ack` in 1: transaction complete. Valid only while `dmem_req` is high.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, with `start` high:
  - Register `is_store`, `mem`, `addr`, `store_data`.
  - If the code is illegal, or the access is misaligned, go to DONE with the fault latched. No memory request is issued.
  - Misaligned means: half with `addr[0]=1`, or word with `addr[1:0]≠0`.
  - Otherwise go to ACCESS.
- ACCESS:
  - `dmem_req` is high and all `dmem_*` outputs are stable.
  - A timeout counter increments each cycle.
  - `dmem_ack` high: capture `dmem_rdata` for loads, then go to DONE with fault 00.
  - Counter reaches `TIMEOUT-1` without ack: go to DONE with fault 10.
  - Ack wins over timeout when both occur in the same cycle.
- DONE: `done`=1 for exactly one cycle, then return to IDLE. `start` is ignored in this state.
- Store strobes and data:
  - byte: `wstrb = 0001 << addr[1:0]`; `wdata = {4{sd[7:0]}}`
  - half: `wstrb = 0011 << addr[1:0]`; `wdata = {2{sd[15:0]}}`
  - word: `wstrb = 1111`; `wdata = sd`
- Loads:
  - `dmem_we`=0 and `wstrb`=0000.
  - Select the lane using `addr[1:0]` (byte) or `addr[1]` (half).
  - Sign-extend for codes 001/010; zero-extend for codes 101/110.
- `load_data` after a store or after a faulted access: holds its previous value.
- `start` while `busy` is high: ignored, not queued.
- Reset, including mid-ACCESS:
  - FSM returns to IDLE and the counter is cleared.
  - All outputs go to 0: `busy`, `done`, `fault`, `load_data`, `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wstrb`, `dmem_wdata`.
  - An outstanding ack arriving after reset is ignored.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- `start` in cycle 0 → `dmem_req` high in cycle 1.
- Ack in cycle k ≥ 1 → `done` and `load_data` valid in cycle k+1 → back in IDLE in cycle k+2. Minimum latency is 2 cycles.
- Faulted request (misaligned or illegal): `done` in cycle 1, `dmem_req` never asserted.
- Timeout: `dmem_req` is high for exactly `TIMEOUT` cycles, in cycles 1..`TIMEOUT`. `done` with fault 10 follows in cycle `TIMEOUT`+1. `dmem_req` drops in the same cycle `done` rises.
- Back-to-back: the earliest next accepted `start` is the cycle after DONE.

## Structure
- Shared package `lsu_pkg`:
  - `mem` code constants (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU)
  - `fault` encodings
  - state enum
- One combinational sub-module, `lsu_align`. Inputs: `mem`, `addr[1:0]`, `store_data`, `rdata`. Outputs: `wstrb`, `wdata`, extended load value, misaligned/illegal flags.
- The top module holds the FSM, the timeout counter and the registers.

## Test plan
- Load byte signed: `addr`=0x103, `rdata`=0x80AA_BBCC, ack in cycle 1 → `load_data`=0xFFFF_FF80, `fault`=00, `done` in cycle 2.
- Load half unsigned: `addr`=0x202, `rdata`=0x8001_1234, ack after 3 wait cycles → `load_data`=0x0000_8001, `done` in cycle 5.
- Store byte: `addr`=0x41, `sd`=0x1234_56A5 → `dmem_wstrb`=0010, `dmem_wdata`=0xA5A5_A5A5, `dmem_addr`=0x40, `dmem_we`=1.
- Load word at `addr`=0x06 → `done` in cycle 1 with `fault`=01, `dmem_req` never high. Repeat with `mem`=111 → `fault`=11.
- `TIMEOUT`=16, no ack → `dmem_req` high for 16 cycles, then `done` with `fault`=10, `load_data` unchanged.
- Assert `rst_n` low mid-ACCESS, then apply a late ack after release → all outputs 0, no `done`. A new `start` completes normally.
